// File: rtl/slow_ctl_pkg.sv
// Shared definitions for the slow-peripheral clock controller.
//   - TwDefault : default width of the hold timeout field and its down-counter
//   - state_e   : FSM state encoding, also driven out on the debug State port
package slow_ctl_pkg;

    localparam int unsigned TwDefault = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StHold   = 2'd2,
        StBad    = 2'd3  // never entered; decoded back to StIdle
    } state_e;

endpackage

// File: rtl/slow_ctl_if.sv
// Bus-side signal bundle for slow_ctl.
//   master modport : CPU/decode side, drives cycle status, strobes, config and tick;
//                    receives slow, clock_gate and state
//   slave modport  : slow_ctl side
// Inputs : bact, *_cs decode strobes, slow_* enables, slow_timeout[TW], timeout_tick
// Outputs: slow (clock switcher request), clock_gate, state[2] (debug)
interface slow_ctl_if
    import slow_ctl_pkg::*;
#(
    parameter int unsigned TW = TwDefault
) ();

    logic          bact;
    logic          iack_cs;
    logic          via_cs;
    logic          iwm_cs;
    logic          scc_cs;
    logic          scsi_cs;
    logic          snd_cs;
    logic          slow_iack;
    logic          slow_via;
    logic          slow_iwm;
    logic          slow_scc;
    logic          slow_scsi;
    logic          slow_snd;
    logic          slow_clock_gate;
    logic [TW-1:0] slow_timeout;
    logic          timeout_tick;
    logic          slow;
    logic          clock_gate;
    logic [1:0]    state;

    modport master (
        output bact, iack_cs, via_cs, iwm_cs, scc_cs, scsi_cs, snd_cs,
        output slow_iack, slow_via, slow_iwm, slow_scc, slow_scsi, slow_snd,
        output slow_clock_gate, slow_timeout, timeout_tick,
        input  slow, clock_gate, state
    );

    modport slave (
        input  bact, iack_cs, via_cs, iwm_cs, scc_cs, scsi_cs, snd_cs,
        input  slow_iack, slow_via, slow_iwm, slow_scc, slow_scsi, slow_snd,
        input  slow_clock_gate, slow_timeout, timeout_tick,
        output slow, clock_gate, state
    );

endinterface

// File: rtl/slow_timer.sv
// Loadable TW-bit hold down-counter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (count -> 0)
//   i_load         : load i_load_val (takes priority over i_tick)
//   i_tick         : decrement by one; ignored when the count is already 0
//   o_count        : current count
//   o_zero         : count == 0
module slow_timer
    import slow_ctl_pkg::*;
#(
    parameter int unsigned TW = TwDefault
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_tick,
    output logic [TW-1:0] o_count,
    output logic          o_zero
);

    logic [TW-1:0] r_count;
    logic [TW-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            w_count_d = r_count - TW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/slow_ctl.sv
// Slow-peripheral controller: asks the clock switcher to run the CPU at stock speed
// while a slow-enabled peripheral is accessed, and for SlowTimeout ticks afterwards.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : strobes, enables, timeout config and tick in; slow, clock_gate,
//                    state out
// Build option: define SLOWCTL_CLKGATE_EN to drive clock_gate = slow & slow_clock_gate
// (registered); otherwise clock_gate is tied low.
module slow_ctl
    import slow_ctl_pkg::*;
#(
    parameter int unsigned TW = TwDefault
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    slow_ctl_if.slave   bus
);

    state_e        r_state;
    state_e        w_state_d;
    logic          r_slow;
    logic          w_slow_d;
    logic          w_hit;
    logic          w_load;
    logic          w_dec;
    logic [TW-1:0] w_count;
    logic          w_zero;
    logic          w_final_tick;

    assign w_hit = bus.bact & |({bus.iack_cs, bus.via_cs, bus.iwm_cs,
                                 bus.scc_cs, bus.scsi_cs, bus.snd_cs} &
                                {bus.slow_iack, bus.slow_via, bus.slow_iwm,
                                 bus.slow_scc, bus.slow_scsi, bus.slow_snd});

    // Counter only moves in HOLD; ticks elsewhere are ignored.
    assign w_load       = (r_state == StActive) && !bus.bact && (bus.slow_timeout != '0);
    assign w_dec        = (r_state == StHold) && bus.timeout_tick;
    assign w_final_tick = w_dec && (w_count == TW'(1));

    slow_timer #(
        .TW (TW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (bus.slow_timeout),
        .i_tick     (w_dec),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_hit) w_state_d = StActive;
            end
            StActive: begin
                if (!bus.bact) begin
                    w_state_d = (bus.slow_timeout == '0) ? StIdle : StHold;
                end
            end
            StHold: begin
                // A new hit wins over a coincident final tick.
                if (w_hit) begin
                    w_state_d = StActive;
                end else if (w_final_tick || w_zero) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_slow_d = (w_state_d == StActive) || (w_state_d == StHold);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_slow  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_slow  <= w_slow_d;
        end
    end

`ifdef SLOWCTL_CLKGATE_EN
    logic r_clock_gate;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clock_gate <= 1'b0;
        end else begin
            r_clock_gate <= w_slow_d & bus.slow_clock_gate;
        end
    end

    assign bus.clock_gate = r_clock_gate;
`else
    logic w_unused_cg;
    assign w_unused_cg    = bus.slow_clock_gate;
    assign bus.clock_gate = 1'b0;
`endif

    assign bus.slow  = r_slow;
    assign bus.state = r_state;

endmodule

// File: tb/tb_slow_ctl.sv
// Directed self-checking bench for slow_ctl.
module tb_slow_ctl;

    localparam int unsigned TW = 4;
`ifdef SLOWCTL_CLKGATE_EN
    localparam logic CgEn = 1'b1;
`else
    localparam logic CgEn = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    slow_ctl_if #(.TW(TW)) bus ();

    slow_ctl #(
        .TW (TW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic sl);
        chk({tag, ".state"}, {2'b00, bus.state}, {2'b00, st});
        chk({tag, ".slow"}, {3'b000, bus.slow}, {3'b000, sl});
        chk({tag, ".cg"}, {3'b000, bus.clock_gate}, {3'b000, sl & bus.slow_clock_gate & CgEn});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.bact = 0; bus.iack_cs = 0; bus.via_cs = 0; bus.iwm_cs = 0;
        bus.scc_cs = 0; bus.scsi_cs = 0; bus.snd_cs = 0;
        bus.slow_iack = 0; bus.slow_via = 0; bus.slow_iwm = 0;
        bus.slow_scc = 0; bus.slow_scsi = 0; bus.slow_snd = 0;
        bus.slow_clock_gate = 0; bus.slow_timeout = '0; bus.timeout_tick = 0;
        #22;
        chk_all("reset", 2'd0, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk_all("post_reset", 2'd0, 1'b0);

        // VIA access, timeout 3
        bus.slow_via = 1; bus.slow_timeout = 4'd3;
        bus.bact = 1; bus.via_cs = 1;
        chk_all("via.before_edge", 2'd0, 1'b0);
        cyc();
        chk_all("via.active", 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_all("via.active_hold", 2'd1, 1'b1);
        end
        bus.bact = 0; bus.via_cs = 0;
        cyc();
        chk_all("via.hold", 2'd2, 1'b1);
        bus.timeout_tick = 1; cyc(); bus.timeout_tick = 0;
        chk_all("via.tick1", 2'd2, 1'b1);
        cyc();
        bus.timeout_tick = 1; cyc(); bus.timeout_tick = 0;
        chk_all("via.tick2", 2'd2, 1'b1);
        cyc();
        chk_all("via.gap", 2'd2, 1'b1);
        bus.timeout_tick = 1; cyc(); bus.timeout_tick = 0;
        chk_all("via.tick3", 2'd0, 1'b0);
        bus.timeout_tick = 1; cyc(); bus.timeout_tick = 0;
        chk_all("idle.tick", 2'd0, 1'b0);

        // SCC strobe with its enable off
        bus.bact = 1; bus.scc_cs = 1;
        cyc();
        chk_all("scc.off1", 2'd0, 1'b0);
        cyc();
        chk_all("scc.off2", 2'd0, 1'b0);
        bus.bact = 0; bus.scc_cs = 0;

        // IWM with zero timeout, tick during ACTIVE
        bus.slow_iwm = 1; bus.slow_timeout = 4'd0;
        bus.bact = 1; bus.iwm_cs = 1;
        cyc();
        chk_all("iwm.active", 2'd1, 1'b1);
        bus.timeout_tick = 1; cyc(); bus.timeout_tick = 0;
        chk_all("iwm.tick_active", 2'd1, 1'b1);
        bus.bact = 0; bus.iwm_cs = 0;
        cyc();
        chk_all("iwm.direct_idle", 2'd0, 1'b0);

        // SCSI: hit coincident with final tick, then reload on exit
        bus.slow_scsi = 1; bus.slow_timeout = 4'd2;
        bus.bact = 1; bus.scsi_cs = 1;
        cyc();
        bus.bact = 0; bus.scsi_cs = 0;
        cyc();
        chk_all("scsi.hold", 2'd2, 1'b1);
        bus.timeout_tick = 1; cyc(); bus.timeout_tick = 0;
        chk_all("scsi.count1", 2'd2, 1'b1);
        bus.slow_timeout = 4'd5;
        bus.bact = 1; bus.scsi_cs = 1; bus.timeout_tick = 1;
        cyc();
        bus.timeout_tick = 0;
        chk_all("scsi.hit_wins", 2'd1, 1'b1);
        cyc();
        bus.bact = 0; bus.scsi_cs = 0;
        cyc();
        chk_all("scsi.reload_hold", 2'd2, 1'b1);
        bus.slow_timeout = 4'd1;  // must not disturb the running count of 5
        bus.timeout_tick = 1;
        for (int i = 0; i < 4; i++) cyc();
        chk_all("scsi.after4", 2'd2, 1'b1);
        cyc();
        bus.timeout_tick = 0;
        chk_all("scsi.after5", 2'd0, 1'b0);

        // Asynchronous reset mid-HOLD at count 2
        bus.slow_timeout = 4'd3;
        bus.bact = 1; bus.via_cs = 1;
        cyc();
        bus.bact = 0; bus.via_cs = 0;
        cyc();
        bus.timeout_tick = 1; cyc(); bus.timeout_tick = 0;
        chk_all("rst.hold_cnt2", 2'd2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rst.async", 2'd0, 1'b0);
        rst_n = 1'b1;
        cyc();
        chk_all("rst.released", 2'd0, 1'b0);
        bus.slow_timeout = 4'd0;
        bus.bact = 1; bus.via_cs = 1;
        cyc();
        chk_all("rst.first_hit", 2'd1, 1'b1);
        bus.bact = 0; bus.via_cs = 0;
        cyc();
        chk_all("rst.back_idle", 2'd0, 1'b0);

        // Sound with clock-gate enable; enable drop mid-ACTIVE
        bus.slow_snd = 1; bus.slow_clock_gate = 1;
        bus.bact = 1; bus.snd_cs = 1;
        cyc();
        chk_all("snd.active", 2'd1, 1'b1);
        bus.slow_snd = 0;
        cyc();
        chk_all("snd.enable_drop", 2'd1, 1'b1);
        bus.bact = 0; bus.snd_cs = 0;
        cyc();
        chk_all("snd.idle", 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/slow_ctl.md
SLOW_CTL -- requirements
Module: slow_ctl

Interface
REQ-001 Parameter: TW, 4, width of timeout field and countdown counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  system clock.
REQ-004 nPOR  in  1  asynchronous active-low reset.
REQ-005 BACT  in  1  CPU bus cycle active.
REQ-006 IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS  in  1 each  peripheral decode strobes, valid while BACT.
REQ-007 SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd, SlowClockGate  in  1 each  per-peripheral slow enables from the configuration register.
REQ-008 SlowTimeout  in  TW  hold period, in ticks.
REQ-009 TimeoutTick  in  1  single-cycle timebase pulse.
REQ-010 Slow  out  1  request to the clock switcher to run the CPU at stock speed.
REQ-011 ClockGate  out  1  accelerator clock-gate request.
REQ-012 State  out  2  current FSM state, for debug.

Function
REQ-013 Hit SHALL equal BACT AND the OR of (each CS AND its matching Slow enable).
REQ-014 FSM states SHALL be IDLE=0, ACTIVE=1 and HOLD=2; encoding 3 is unreachable and SHALL return to IDLE.
REQ-015 IDLE: Hit moves to ACTIVE on the next edge.
REQ-016 ACTIVE: stays while BACT=1; on BACT=0 moves to IDLE if SlowTimeout=0, otherwise to HOLD with the counter loaded from SlowTimeout.
REQ-017 HOLD: TimeoutTick decrements the counter; a tick when count=1 moves to IDLE.
REQ-018 HOLD: Hit moves to ACTIVE, and the counter reloads on the next ACTIVE exit.
REQ-019 Hit and the final tick in the same cycle SHALL resolve to ACTIVE.
REQ-020 Slow SHALL be registered and equal 1 in ACTIVE and HOLD; latency is 1 cycle from sampled Hit to Slow=1 and 1 cycle from the final tick to Slow=0.
REQ-021 A SlowTimeout change during HOLD SHALL NOT alter the running count; the new value applies at the next load.
REQ-022 A Slow-enable change during ACTIVE SHALL NOT abort ACTIVE.
REQ-023 The counter SHALL never wrap below 0; a tick at count=0 is ignored.
REQ-024 TimeoutTick in IDLE or ACTIVE SHALL have no effect.

Reset
REQ-025 nPOR=0 SHALL asynchronously force State=IDLE, counter=0, Slow=0 and ClockGate=0, including mid-ACTIVE or mid-HOLD.
REQ-026 After nPOR deasserts, the first Hit SHALL behave as from IDLE.

Configuration
REQ-027 With SLOWCTL_CLKGATE_EN defined, ClockGate SHALL be registered and equal Slow AND SlowClockGate.
REQ-028 Without SLOWCTL_CLKGATE_EN, ClockGate SHALL be constant 0 and SlowClockGate unused.

Structure
REQ-029 The shared package SHALL hold the state encoding constants and TW default.
REQ-030 Sub-module slow_timer SHALL contain the loadable TW-bit down-counter with tick decrement and zero flag; the FSM SHALL stay in slow_ctl.

Verification
REQ-031 SlowVIA=1, SlowTimeout=3, a 4-cycle VIACS access -> Slow=1 the cycle after Hit; after BACT falls, Slow=0 one cycle after the 3rd tick.
REQ-032 SlowSCC=0, SCCCS access -> Slow stays 0 and State stays IDLE.
REQ-033 SlowTimeout=0, IWMCS access -> ACTIVE to IDLE directly; Slow=0 the cycle after BACT falls.
REQ-034 HOLD at count=1, SCSICS Hit coincident with a tick -> State=ACTIVE, Slow stays 1, counter reloads to SlowTimeout on exit.
REQ-035 nPOR pulsed low mid-HOLD (count=2) -> Slow=0 and State=0 immediately, without waiting for a clock edge.
REQ-036 SLOWCTL_CLKGATE_EN defined, SlowClockGate=1, SndCS access -> ClockGate tracks Slow; macro undefined -> ClockGate=0 throughout.
